// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the BCD counter.
// Patterns are active low and ordered {a,b,c,d,e,f,g}: bit 6 = a, bit 0 = g.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    // Shown for non-BCD codes and while a rejected load is flagged
    localparam logic [6:0] SEG_ERR   = 7'b0101010;

    // All segments off, used for blanked leading zeros
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Map each decimal code to its glyph; anything above 9 shows the error glyph
    always_comb begin
        seg = SEG_ERR;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/multi_digit_bcd_counter.sv
// Multi-digit BCD up/down counter with prescaled tick, validated load,
// sticky load-error flag and registered seven-segment outputs.
module multi_digit_bcd_counter
    import seg7_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 50000000,
    parameter int BLANK_LZ = 0
)
(
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                EN,
    input  logic                UP,
    input  logic                LOAD,
    input  logic [4*NDIG-1:0]   LOAD_VAL,
    output logic [7*NDIG-1:0]   HEX,
    output logic [4*NDIG-1:0]   COUNT,
    output logic                TC,
    output logic                ERR
);

    localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   PRE_ONE = PW'(1);

    logic [PW-1:0]      pre;
    logic               tick;
    logic [4*NDIG-1:0]  count_next;
    logic               chain;
    logic               wrap;
    logic               load_ok;
    logic               upper_zero;
    logic [NDIG-1:0]    blank;
    logic [7*NDIG-1:0]  seg_raw;
    logic [7*NDIG-1:0]  hex_next;
    logic [7*NDIG-1:0]  hex_reset;

    // Free-running prescaler; the tick marks its last cycle before wrapping
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            pre <= '0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_ONE;
        end
    end

    assign tick = (pre == PRE_MAX);

    // Ripple carry/borrow: a digit moves only when all lower digits are at their limit
    always_comb begin
        chain      = 1'b1;
        count_next = COUNT;
        for (int i = 0; i < NDIG; i++) begin
            if (chain) begin
                if (UP) begin
                    count_next[4*i +: 4] = (COUNT[4*i +: 4] == 4'd9) ? 4'd0 : COUNT[4*i +: 4] + 4'd1;
                end else begin
                    count_next[4*i +: 4] = (COUNT[4*i +: 4] == 4'd0) ? 4'd9 : COUNT[4*i +: 4] - 4'd1;
                end
            end
            chain = chain & (UP ? (COUNT[4*i +: 4] == 4'd9) : (COUNT[4*i +: 4] == 4'd0));
        end
        wrap = chain;
    end

    // A preset is accepted only if every nibble is a decimal digit
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (LOAD_VAL[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Count register: load beats tick, bad loads hold the count and raise ERR
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            COUNT <= '0;
            TC    <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            TC <= 1'b0;
            if (LOAD) begin
                if (load_ok) begin
                    COUNT <= LOAD_VAL;
                    ERR   <= 1'b0;
                end else begin
                    ERR   <= 1'b1;
                end
            end else if (tick && EN) begin
                COUNT <= count_next;
                TC    <= wrap;
            end
        end
    end

    // Leading-zero mask: a digit blanks when it and all digits above it are zero
    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (COUNT[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LZ != 0) && upper_zero;
        end
    end

    // One decoder per digit
    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        bcd_to_seg7 u_dec (
            .bcd (COUNT[4*g +: 4]),
            .seg (seg_raw[7*g +: 7])
        );
    end

    // Select what each display shows next: error glyph, blank, or the decoded digit
    always_comb begin
        hex_next  = '0;
        hex_reset = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (ERR) begin
                hex_next[7*i +: 7] = SEG_ERR;
            end else if (blank[i]) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*i +: 7] = seg_raw[7*i +: 7];
            end
            hex_reset[7*i +: 7] = ((i != 0) && (BLANK_LZ != 0)) ? SEG_BLANK : SEG_0;
        end
    end

    // Display register, one cycle behind COUNT/ERR
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            HEX <= hex_reset;
        end else begin
            HEX <= hex_next;
        end
    end

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Self-checking bench: two counters (plain and leading-zero blanked) run from
// the same stimulus and are compared every cycle against an integer model.
module tb_multi_digit_bcd_counter;

    localparam int NDIG     = 2;
    localparam int PRESCALE = 4;

    logic        clock_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        en       = 1'b0;
    logic        up       = 1'b1;
    logic        load     = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic [13:0] hex_a, hex_b;
    logic [7:0]  count_a, count_b;
    logic        tc_a, tc_b, err_a, err_b;

    int total = 0;
    int bad   = 0;

    int          m_cnt = 0;
    int          m_pre = 0;
    bit          m_tc  = 1'b0;
    bit          m_err = 1'b0;
    logic [13:0] m_hex_a, m_hex_b;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always #5 clock_50 = ~clock_50;

    multi_digit_bcd_counter #(.NDIG(NDIG), .PRESCALE(PRESCALE), .BLANK_LZ(0)) dut_a (
        .CLOCK_50 (clock_50),
        .RESET    (reset),
        .EN       (en),
        .UP       (up),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .HEX      (hex_a),
        .COUNT    (count_a),
        .TC       (tc_a),
        .ERR      (err_a)
    );

    multi_digit_bcd_counter #(.NDIG(NDIG), .PRESCALE(PRESCALE), .BLANK_LZ(1)) dut_b (
        .CLOCK_50 (clock_50),
        .RESET    (reset),
        .EN       (en),
        .UP       (up),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .HEX      (hex_b),
        .COUNT    (count_b),
        .TC       (tc_b),
        .ERR      (err_b)
    );

    // Expected display for a decimal value 0..99
    function automatic logic [13:0] display(int c, bit e, bit blank_lz);
        logic [6:0] hi;
        logic [6:0] lo;
        if (e) return {7'b0101010, 7'b0101010};
        hi = seg_tab[c / 10];
        lo = seg_tab[c % 10];
        if (blank_lz && (c / 10 == 0)) hi = 7'b1111111;
        return {hi, lo};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then check
    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [7:0] v);
        int  old_cnt;
        bit  old_err;
        bit  tick;
        int  hi;
        int  lo;
        logic [7:0] exp_bcd;
        reset = r; en = e; up = u; load = l; load_val = v;
        @(posedge clock_50);
        old_cnt = m_cnt;
        old_err = m_err;
        tick    = (m_pre == PRESCALE - 1);
        hi      = int'(v[7:4]);
        lo      = int'(v[3:0]);
        if (r) begin
            m_cnt = 0; m_pre = 0; m_tc = 1'b0; m_err = 1'b0;
            m_hex_a = display(0, 1'b0, 1'b0);
            m_hex_b = display(0, 1'b0, 1'b1);
        end else begin
            m_pre = (m_pre + 1) % PRESCALE;
            m_tc  = 1'b0;
            if (l) begin
                if (hi <= 9 && lo <= 9) begin
                    m_cnt = hi * 10 + lo;
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (tick && e) begin
                if (u) begin
                    m_tc  = (old_cnt == 99);
                    m_cnt = (old_cnt + 1) % 100;
                end else begin
                    m_tc  = (old_cnt == 0);
                    m_cnt = (old_cnt + 99) % 100;
                end
            end
            m_hex_a = display(old_cnt, old_err, 1'b0);
            m_hex_b = display(old_cnt, old_err, 1'b1);
        end
        #1;
        exp_bcd = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        checkOutput("count_a", 32'(count_a), 32'(exp_bcd));
        checkOutput("count_b", 32'(count_b), 32'(exp_bcd));
        checkOutput("tc",      32'(tc_a),    32'(m_tc));
        checkOutput("err",     32'(err_a),   32'(m_err));
        checkOutput("hex_a",   32'(hex_a),   32'(m_hex_a));
        checkOutput("hex_b",   32'(hex_b),   32'(m_hex_b));
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        applyStimulus(1, 0, 1, 0, 8'h00);
        applyStimulus(1, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);

        applyStimulus(1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 40; i++) applyStimulus(0, 1, 1, 0, 8'h00);

        applyStimulus(0, 1, 1, 1, 8'h99);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(0, 1, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 8'h00);

        applyStimulus(0, 0, 1, 1, 8'h3A);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 1, 8'h42);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 8'h00);

        for (int i = 0; i < PRESCALE && m_pre != PRESCALE - 1; i++) applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 1, 8'h25);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 0, 8'h00);

        applyStimulus(0, 0, 1, 1, 8'h07);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 1, 8'h00);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 8'h00);

        applyStimulus(0, 1, 1, 1, 8'h57);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(1, 1, 1, 0, 8'h00);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 1, 0, 8'h00);

        for (int i = 0; i < 600; i++) begin
            logic [7:0] v;
            int         r;
            r = int'($urandom_range(0, 99));
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 9) == 0) v = ($urandom_range(0, 1) == 1) ? 8'h99 : 8'h00;
            applyStimulus(r < 2, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                          (r >= 2) && (r < 10), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
